// File: rtl/axi_obi_pkg.sv
// Shared types for the AXI-to-OBI bridge: FSM states, AXI response/burst
// encodings and the axi_32 channel structs used across the interconnect.
package axi_obi_pkg;

    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_USER_WIDTH = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_REQ,
        WR_WAIT,
        WR_RESP,
        RD_REQ,
        RD_WAIT,
        RD_RESP
    } state_e;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic                      lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
        logic [3:0]                qos;
        logic [3:0]                region;
        logic [5:0]                atop;
        logic [AXI_USER_WIDTH-1:0] user;
    } axi_32_aw_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic                      lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
        logic [3:0]                qos;
        logic [3:0]                region;
        logic [AXI_USER_WIDTH-1:0] user;
    } axi_32_ar_chan_t;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0]   data;
        logic [AXI_DATA_WIDTH/8-1:0] strb;
        logic                        last;
        logic [AXI_USER_WIDTH-1:0]   user;
    } axi_32_w_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [1:0]                resp;
        logic [AXI_USER_WIDTH-1:0] user;
    } axi_32_b_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
        logic [AXI_USER_WIDTH-1:0] user;
    } axi_32_r_chan_t;

    typedef struct packed {
        axi_32_aw_chan_t aw;
        logic            aw_valid;
        axi_32_w_chan_t  w;
        logic            w_valid;
        logic            b_ready;
        axi_32_ar_chan_t ar;
        logic            ar_valid;
        logic            r_ready;
    } axi_32_req_t;

    typedef struct packed {
        logic           aw_ready;
        logic           ar_ready;
        logic           w_ready;
        logic           b_valid;
        axi_32_b_chan_t b;
        logic           r_valid;
        axi_32_r_chan_t r;
    } axi_32_resp_t;

endpackage

// File: rtl/axi_obi_addr_gen.sv
// Next beat address for FIXED/INCR bursts; flags WRAP and reserved bursts,
// which the bridge answers with SLVERR instead of touching OBI.
module axi_obi_addr_gen
    import axi_obi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o,
    output logic                  err_o
);

    // NOTE: every output gets a default before the case, so no latch is inferred.
    always_comb begin
        next_addr_o = addr_i;
        err_o       = 1'b0;
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_INCR:  next_addr_o = addr_i + (ADDR_WIDTH'(1) << size_i);
            default:     err_o       = 1'b1;
        endcase
    end

endmodule

// File: rtl/axi_obi_adapter.sv
// AXI4 subordinate to OBI manager bridge: each AXI beat becomes exactly one
// OBI transaction, with a single transaction outstanding at a time.
module axi_obi_adapter
    import axi_obi_pkg::*;
#(
    parameter type axi_req_t  = axi_32_req_t,
    parameter type axi_resp_t = axi_32_resp_t,
    parameter int  DATA_WIDTH = 32,
    parameter int  ADDR_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  axi_req_t                axi_req_i,
    output axi_resp_t               axi_resp_o,
    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    input  logic                    obi_rvalid_i,
    output logic                    obi_we_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic [DATA_WIDTH-1:0]   obi_wdata_o,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i
);

    state_e                    state;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [ADDR_WIDTH-1:0]     next_addr;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [7:0]                len_q;
    logic [7:0]                beat_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [DATA_WIDTH/8-1:0]   strb_q;
    logic                      last_was_write;
    logic                      burst_err;
    logic                      idle;
    logic                      take_wr;
    logic                      take_rd;
    logic                      last_beat;
    logic                      unused_req;

    // Only a subset of the request fields matters; the rest is deliberately ignored.
    assign unused_req = ^axi_req_i;

    axi_obi_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr),
        .err_o       (burst_err)
    );

    // Readies are gated by reset so nothing is accepted while it is held.
    assign idle      = (state == IDLE) && !rst_i;
    assign take_wr   = idle && axi_req_i.aw_valid && (!axi_req_i.ar_valid || !last_was_write);
    assign take_rd   = idle && axi_req_i.ar_valid && (!axi_req_i.aw_valid || last_was_write);
    assign last_beat = (beat_q == len_q);

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = take_wr;
        axi_resp_o.ar_ready = take_rd;
        axi_resp_o.w_ready  = (state == WR_DATA);
        axi_resp_o.b_valid  = (state == WR_RESP);
        axi_resp_o.b.id     = id_q;
        axi_resp_o.b.resp   = burst_err ? RESP_SLVERR : RESP_OKAY;
        axi_resp_o.r_valid  = (state == RD_RESP);
        axi_resp_o.r.id     = id_q;
        axi_resp_o.r.data   = rdata_q;
        axi_resp_o.r.last   = last_beat;
        axi_resp_o.r.resp   = burst_err ? RESP_SLVERR : RESP_OKAY;
    end

    assign obi_req_o   = (state == WR_REQ) || ((state == RD_REQ) && !burst_err);
    assign obi_we_o    = (state == WR_REQ);
    assign obi_be_o    = obi_we_o ? strb_q : {(DATA_WIDTH/8){1'b1}};
    assign obi_addr_o  = addr_q;
    assign obi_wdata_o = wdata_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            addr_q         <= '0;
            id_q           <= '0;
            len_q          <= '0;
            beat_q         <= '0;
            size_q         <= '0;
            burst_q        <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            strb_q         <= '0;
            last_was_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_wr) begin
                        addr_q         <= axi_req_i.aw.addr;
                        id_q           <= axi_req_i.aw.id;
                        len_q          <= axi_req_i.aw.len;
                        size_q         <= axi_req_i.aw.size;
                        burst_q        <= axi_req_i.aw.burst;
                        beat_q         <= '0;
                        last_was_write <= 1'b1;
                        state          <= WR_DATA;
                    end else if (take_rd) begin
                        addr_q         <= axi_req_i.ar.addr;
                        id_q           <= axi_req_i.ar.id;
                        len_q          <= axi_req_i.ar.len;
                        size_q         <= axi_req_i.ar.size;
                        burst_q        <= axi_req_i.ar.burst;
                        beat_q         <= '0;
                        last_was_write <= 1'b0;
                        state          <= RD_REQ;
                    end
                end
                WR_DATA: begin
                    if (axi_req_i.w_valid) begin
                        wdata_q <= axi_req_i.w.data;
                        strb_q  <= axi_req_i.w.strb;
                        // Unsupported bursts drain W beats without any OBI access.
                        if (!burst_err) begin
                            state <= WR_REQ;
                        end else if (last_beat) begin
                            state <= WR_RESP;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                WR_REQ: begin
                    if (obi_gnt_i) state <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (obi_rvalid_i) begin
                        if (last_beat) begin
                            state <= WR_RESP;
                        end else begin
                            addr_q <= next_addr;
                            beat_q <= beat_q + 8'd1;
                            state  <= WR_DATA;
                        end
                    end
                end
                WR_RESP: begin
                    if (axi_req_i.b_ready) state <= IDLE;
                end
                RD_REQ: begin
                    if (burst_err) begin
                        rdata_q <= '0;
                        state   <= RD_RESP;
                    end else if (obi_gnt_i) begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (obi_rvalid_i) begin
                        rdata_q <= obi_rdata_i;
                        state   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (axi_req_i.r_ready) begin
                        if (last_beat) begin
                            state <= IDLE;
                        end else begin
                            addr_q <= next_addr;
                            beat_q <= beat_q + 8'd1;
                            state  <= RD_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
